char_buffer_ctrl: RTL

Owns the 512-entry character-code buffer (16 rows x 32 columns) that feeds the text-box overlay. It serves overlay reads on char_xy with fixed latency. On request from game logic, it optionally clears the buffer, then copies a NUL-terminated message from an external message ROM to a chosen start cell. All buffer writes happen only while vblnk_in is high, so a frame never shows a half-updated buffer.

---
 rtl/char_buffer_ctrl_pkg.sv | 24 ++
 rtl/char_buffer_ctrl_if.sv | 33 +++
 rtl/char_buffer_ram.sv | 39 +++
 rtl/char_buffer_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/char_buffer_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Package : char_buffer_ctrl_pkg
// Brief   : Geometry, blank code and FSM encoding shared by the char buffer.
// Rev     : 1.0 - initial release
//============================================================================
package char_buffer_ctrl_pkg;

  localparam int COLS      = 32;
  localparam int ROWS      = 16;
  localparam int BUF_DEPTH = ROWS * COLS;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);

  localparam logic [6:0] BLANK_CODE = 7'h20;

  localparam logic [2:0] ST_INIT_CLR = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_CLEAR    = 3'd2;
  localparam logic [2:0] ST_COPY_RD  = 3'd3;
  localparam logic [2:0] ST_COPY_WR  = 3'd4;
  localparam logic [2:0] ST_FIN      = 3'd5;

endpackage
`default_nettype wire

// File: rtl/char_buffer_ctrl_if.sv
`default_nettype none
//============================================================================
// Interface : char_buffer_ctrl_if
// Brief     : Overlay read port, message request and message ROM bus.
// Rev       : 1.0 - initial release
//============================================================================
interface char_buffer_ctrl_if #(
  parameter int CODE_W = 7,
  parameter int ID_W   = 3
);
  logic              vblnk_in;
  logic [8:0]        char_xy;
  logic [CODE_W-1:0] char_code;
  logic              msg_req;
  logic [ID_W-1:0]   msg_id;
  logic [8:0]        msg_pos;
  logic              msg_clr;
  logic [ID_W+8:0]   msg_rd_addr;
  logic [CODE_W-1:0] msg_char;
  logic              busy;
  logic              done;

  modport master (
    output vblnk_in, char_xy, msg_req, msg_id, msg_pos, msg_clr, msg_char,
    input  char_code, msg_rd_addr, busy, done
  );

  modport slave (
    input  vblnk_in, char_xy, msg_req, msg_id, msg_pos, msg_clr, msg_char,
    output char_code, msg_rd_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/char_buffer_ram.sv
`default_nettype none
//============================================================================
// Module : char_buffer_ram
// Brief  : 512-entry character store, one write port, registered read port.
// Rev    : 1.0 - initial release
//============================================================================
module char_buffer_ram
  import char_buffer_ctrl_pkg::*;
#(
  parameter int DATA_W = 7
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              we,
  input  wire logic [BUF_AW-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [BUF_AW-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read-before-write: a colliding read returns the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/char_buffer_ctrl.sv
`default_nettype none
//============================================================================
// Module : char_buffer_ctrl
// Brief  : Text-box character buffer with vblank-gated clear and message copy.
// Rev    : 1.0 - initial release
//============================================================================
module char_buffer_ctrl
  import char_buffer_ctrl_pkg::*;
#(
  parameter int               CODE_W     = 7,
  parameter int               ID_W       = 3,
  parameter logic [CODE_W-1:0] BLANK_CODE = char_buffer_ctrl_pkg::BLANK_CODE
) (
  input wire logic           clk,
  input wire logic           rst,
  char_buffer_ctrl_if.slave  bus
);

  localparam logic [BUF_AW-1:0] c_last_addr = BUF_AW'(BUF_DEPTH - 1);

  logic [2:0]        r_state;
  logic [BUF_AW-1:0] r_clr_addr;
  logic [ID_W-1:0]   r_id;
  logic [BUF_AW-1:0] r_pos;
  logic [BUF_AW-1:0] r_offset;
  logic [CODE_W-1:0] r_data;
  logic              r_first;

  logic              w_is_clr;
  logic [CODE_W-1:0] w_char;
  logic              w_we;
  logic [BUF_AW-1:0] w_waddr;
  logic [CODE_W-1:0] w_wdata;

  // On the first COPY_WR cycle the ROM word is live; afterwards use the held copy.
  always_comb begin
    w_is_clr = (r_state == ST_INIT_CLR) || (r_state == ST_CLEAR);
    w_char   = r_first ? bus.msg_char : r_data;
    w_we     = 1'b0;
    w_waddr  = r_clr_addr;
    w_wdata  = BLANK_CODE;
    if (w_is_clr && bus.vblnk_in) begin
      w_we = 1'b1;
    end else if ((r_state == ST_COPY_WR) && (w_char != '0) && bus.vblnk_in) begin
      w_we    = 1'b1;
      w_waddr = r_pos + r_offset;
      w_wdata = w_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT_CLR;
      r_clr_addr <= '0;
      r_id       <= '0;
      r_pos      <= '0;
      r_offset   <= '0;
      r_data     <= '0;
      r_first    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT_CLR, ST_CLEAR: begin
          if (bus.vblnk_in) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == c_last_addr) begin
              r_state <= (r_state == ST_INIT_CLR) ? ST_IDLE : ST_COPY_RD;
            end
          end
        end
        ST_IDLE: begin
          if (bus.msg_req) begin
            r_id       <= bus.msg_id;
            r_pos      <= bus.msg_pos;
            r_offset   <= '0;
            r_clr_addr <= '0;
            r_state    <= bus.msg_clr ? ST_CLEAR : ST_COPY_RD;
          end
        end
        ST_COPY_RD: begin
          if (bus.vblnk_in) begin
            r_first <= 1'b1;
            r_state <= ST_COPY_WR;
          end
        end
        ST_COPY_WR: begin
          r_first <= 1'b0;
          if (r_first) begin
            r_data <= bus.msg_char;
          end
          if (w_char == '0) begin
            r_state <= ST_FIN;
          end else if (bus.vblnk_in) begin
            if (r_offset == c_last_addr) begin
              r_state <= ST_FIN;
            end else begin
              r_offset <= r_offset + 1'b1;
              r_state  <= ST_COPY_RD;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_INIT_CLR;
        end
      endcase
    end
  end

  assign bus.msg_rd_addr = {r_id, r_offset};
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_FIN);

  char_buffer_ram #(
    .DATA_W (CODE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (bus.char_xy),
    .rdata (bus.char_code)
  );

endmodule
`default_nettype wire
